// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 sequencer driving an external combinational round datapath.
// Optional abort port enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_CTRL_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] key_i,
    input  logic [127:0] pt_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] ct_o,
    output logic         busy_o,
    output logic [3:0]   round_o,
    output logic [127:0] dp_state_o,
    output logic [127:0] dp_rkey_o,
    output logic [7:0]   dp_rcon_o,
    output logic         dp_final_o,
    input  logic [127:0] dp_state_i,
    input  logic [127:0] dp_rkey_i
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [3:0] LAST = 4'(ROUNDS);

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon;
    logic         abort;

`ifdef AES_CTRL_ABORT_EN
    assign abort = abort_i && (fsm_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        round_d = round_q;
        case (fsm_q)
            IDLE: if (in_valid_i) begin
                state_d = pt_i ^ key_i;
                rkey_d  = key_i;
                round_d = 4'd1;
                fsm_d   = RUN;
            end
            RUN: begin
                state_d = dp_state_i;
                rkey_d  = dp_rkey_i;
                round_d = (round_q == LAST) ? 4'd0 : round_q + 4'd1;
                fsm_d   = (round_q == LAST) ? DONE : RUN;
            end
            DONE: if (out_ready_i) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
        if (abort) begin
            fsm_d   = IDLE;
            state_d = '0;
            rkey_d  = '0;
            round_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign in_ready_o  = fsm_q == IDLE;
    assign out_valid_o = fsm_q == DONE;
    assign busy_o      = fsm_q == RUN;
    assign round_o     = round_q;
    assign ct_o        = state_q;
    assign dp_state_o  = state_q;
    assign dp_rkey_o   = rkey_q;
    assign dp_rcon_o   = busy_o ? rcon : 8'h00;
    assign dp_final_o  = busy_o && (round_q == LAST);
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench with a behavioural AES round/key-expansion datapath model.
module tb_aes_round_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] key = '0;
    logic [127:0] pt = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ct;
    logic         busy;
    logic [3:0]   round;
    logic [127:0] dp_state_o, dp_rkey_o, dp_state_i, dp_rkey_i, nxt_state, nxt_key;
    logic [7:0]   dp_rcon;
    logic         dp_final;
    int           n_err = 0;
    int           n_chk = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .in_valid_i(in_valid), .in_ready_o(in_ready), .key_i(key), .pt_i(pt),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .ct_o(ct),
        .busy_o(busy), .round_o(round),
        .dp_state_o(dp_state_o), .dp_rkey_o(dp_rkey_o), .dp_rcon_o(dp_rcon),
        .dp_final_o(dp_final), .dp_state_i(dp_state_i), .dp_rkey_i(dp_rkey_i)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [7:0] r = a;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Inverse as a^254 by square-and-multiply, then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s = gmul(a, a);
        logic [7:0] v = 8'h01;
        for (int i = 1; i < 8; i++) begin
            v = gmul(v, s);
            s = gmul(s, s);
        end
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {k[23:0], k[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*c] = b[w+4*((c+w)%4)];
        if (!fin)
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    always_comb begin
        nxt_key   = kexp(dp_rkey_o, dp_rcon);
        nxt_state = aes_round(dp_state_o, nxt_key, dp_final);
    end

    // Garbage outside RUN so a controller that samples the datapath there is caught.
    assign dp_state_i = busy ? nxt_state : {4{32'hdeadbeef}};
    assign dp_rkey_i  = busy ? nxt_key : {4{32'hbadc0ffe}};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic [127:0] k, input logic [127:0] p);
        key = k; pt = p; in_valid = 1'b1;
        check("start_ready", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n = 0;
        while (round != r && n < 20) begin step(); n++; end
        check("wait_round", 128'(round), 128'(r));
    endtask

    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] p,
                             input logic [127:0] c);
        int n = 0;
        out_ready = 1'b0;
        start(k, p);
        while (!out_valid && n < 30) begin step(); n++; end
        check({tag, "_valid"}, 128'(out_valid), 128'd1);
        check({tag, "_ct"}, ct, c);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic watch_no_valid(input string tag);
        int seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            step();
        end
        check(tag, 128'(seen), 128'd0);
    endtask

    initial begin
        logic [79:0]  rcv;
        logic [127:0] ct_hold;
        int           hs2, n;
        bit           got_a;
        rcv = 80'h01020408102040801b36;

        step(); step();
        rst_n = 1'b1;
        check("rst_ready", 128'(in_ready), 128'd1);
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_round", 128'(round), 128'd0);
        check("rst_ct", ct, '0);
        check("rst_dp_state", dp_state_o, '0);
        check("rst_dp_rkey", dp_rkey_o, '0);
        check("rst_dp_rcon_final", {dp_rcon, dp_final}, '0);

        // FIPS-197 C.1 with round/Rcon/final trace, then backpressure.
        start(K1, P1);
        for (int r = 1; r <= 10; r++) begin
            check($sformatf("trace_r%0d", r), {busy, round, dp_rcon, dp_final},
                  {1'b1, 4'(r), rcv[8*(10-r) +: 8], r == 10});
            step();
        end
        check("c1_valid", 128'(out_valid), 128'd1);
        check("c1_ct", ct, C1);
        ct_hold = ct;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2); key = K2; pt = P2;
            check($sformatf("bp_%0d", i), {ct, out_valid, in_ready, busy},
                  {ct_hold, 1'b1, 1'b0, 1'b0});
            step();
        end
        in_valid = 1'b0;
        check("bp_hold", {ct, out_valid, round}, {ct_hold, 1'b1, 4'd0});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("accepted", {ct, out_valid, in_ready}, {C1, 1'b0, 1'b1});

        // Back-to-back: in_valid held high, two blocks, consumer always ready.
        out_ready = 1'b1;
        key = K1; pt = P1; in_valid = 1'b1;
        check("b2b_hs1", 128'(in_ready), 128'd1);
        step();
        key = K2; pt = P2;
        hs2 = -1; got_a = 0;
        for (int c = 1; c < 40 && hs2 < 0; c++) begin
            if (out_valid && !got_a) begin
                got_a = 1;
                check("b2b_a_cycle", 128'(c), 128'd11);
                check("b2b_a_ct", ct, C1);
            end
            if (in_ready) hs2 = c;
            step();
        end
        in_valid = 1'b0;
        check("b2b_hs2_cycle", 128'(hs2), 128'd12);
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        check("b2b_b_lat", 128'(n), 128'd10);
        check("b2b_b_ct", ct, C2);
        step();
        out_ready = 1'b0;

        // Reset while round_o==5.
        start(K1, P1);
        wait_round(4'd5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst", {in_ready, busy, out_valid, round, dp_rcon, dp_final},
              {1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0});
        check("mid_rst_dp", {dp_state_o, dp_rkey_o} != '0, 128'd0);
        watch_no_valid("mid_rst_novalid");
        run_block("after_rst", K2, P2, C2);

`ifdef AES_CTRL_ABORT_EN
        start(K2, P2);
        wait_round(4'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort", {in_ready, busy, out_valid, round}, {1'b1, 1'b0, 1'b0, 4'd0});
        check("abort_clr", {dp_state_o, dp_rkey_o} != '0, 128'd0);
        watch_no_valid("abort_novalid");
        run_block("after_abort", K1, P1, C1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
